// File: rtl/jtkicker_rom_pkg.sv
// Shared types and constants for the kicker graphics ROM slot.
// FSM encoding, default client width and cache geometry.
package jtkicker_rom_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WLO  = 2'd2,
      ST_WHI  = 2'd3
   } state_e;

   localparam int ROM_AW    = 13;
   localparam int N_ENTRIES = 2;

endpackage

// File: rtl/jtkicker_rom_slot_if.sv
// Client + SDRAM arbiter signals of one ROM slot.
// master = layer/arbiter side, slave = the slot.
interface jtkicker_rom_slot_if
   import jtkicker_rom_pkg::*;
#(
   parameter int AW = ROM_AW
);
   logic [AW-1:0] addr;
   logic          cs;
   logic          flush;
   logic          ok;
   logic [31:0]   dout;
   logic [21:0]   sdram_addr;
   logic          sdram_req;
   logic          sdram_ack;
   logic          data_rdy;
   logic [15:0]   sdram_din;

   modport master (
      output addr, cs, flush,
      output sdram_ack, data_rdy, sdram_din,
      input  ok, dout, sdram_addr, sdram_req
   );

   modport slave (
      input  addr, cs, flush,
      input  sdram_ack, data_rdy, sdram_din,
      output ok, dout, sdram_addr, sdram_req
   );
endinterface

// File: rtl/jtkicker_rom_cache.sv
// Two-entry tagged word cache with one LRU bit.
// Lookup is combinational; fills land in the LRU entry.
module jtkicker_rom_cache
   import jtkicker_rom_pkg::*;
#(
   parameter int AW = ROM_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] addr_i,
   input  logic          cs_i,
   input  logic          flush_i,
   input  logic          fill_i,
   input  logic          fill_vld_i,
   input  logic [AW-1:0] fill_tag_i,
   input  logic [31:0]   fill_data_i,
   output logic          ok_o,
   output logic [31:0]   dout_o
);
   logic [N_ENTRIES-1:0] vld_q, vld_d;
   logic [N_ENTRIES-1:0] hit;
   logic [AW-1:0]        tag_q  [N_ENTRIES];
   logic [31:0]          data_q [N_ENTRIES];
   logic                 lru_q, lru_d;

   always_comb begin
      hit = '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
         hit[i] = vld_q[i] && (tag_q[i] == addr_i);
      end
   end

   assign ok_o   = cs_i && (|hit);
   assign dout_o = hit[1] ? data_q[1] :
                   hit[0] ? data_q[0] : '0;

   // a fill owns the LRU bit that cycle; flush beats everything
   always_comb begin
      vld_d = vld_q;
      lru_d = lru_q;
      if (fill_i) begin
         vld_d[lru_q] = fill_vld_i;
         lru_d        = ~lru_q;
      end else if (ok_o) begin
         lru_d = hit[0];
      end
      if (flush_i) begin
         vld_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         lru_q <= 1'b0;
         for (int i = 0; i < N_ENTRIES; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         lru_q <= lru_d;
         if (fill_i) begin
            tag_q[lru_q]  <= fill_tag_i;
            data_q[lru_q] <= fill_data_i;
         end
      end
   end

endmodule

// File: rtl/jtkicker_rom_slot.sv
// Graphics ROM slot: cache lookup plus two-word SDRAM burst on miss.
// A started burst always completes; flush only poisons its fill.
module jtkicker_rom_slot
   import jtkicker_rom_pkg::*;
#(
   parameter int          AW     = ROM_AW,
   parameter logic [21:0] OFFSET = 22'h0
) (
   input  logic               clk,
   input  logic               rst,
   jtkicker_rom_slot_if.slave bus
);
   state_e        state_q, state_d;
   logic [AW-1:0] tag_q, tag_d;
   logic [15:0]   lo_q, lo_d;
   logic          flushed_q, flushed_d;
   logic          ok_w;
   logic [31:0]   dout_w;
   logic          req_w;
   logic          fill_en;
   logic          fill_vld;

   jtkicker_rom_cache #(
      .AW (AW)
   ) u_cache (
      .clk         (clk),
      .rst         (rst),
      .addr_i      (bus.addr),
      .cs_i        (bus.cs),
      .flush_i     (bus.flush),
      .fill_i      (fill_en),
      .fill_vld_i  (fill_vld),
      .fill_tag_i  (tag_q),
      .fill_data_i ({bus.sdram_din, lo_q}),
      .ok_o        (ok_w),
      .dout_o      (dout_w)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         tag_q     <= '0;
         lo_q      <= '0;
         flushed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tag_q     <= tag_d;
         lo_q      <= lo_d;
         flushed_q <= flushed_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      tag_d     = tag_q;
      lo_d      = lo_q;
      flushed_d = flushed_q | bus.flush;
      unique case (state_q)
         ST_IDLE: begin
            flushed_d = 1'b0;
            if (bus.cs && !ok_w && !bus.flush) begin
               tag_d   = bus.addr;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus.sdram_ack) begin
               if (bus.data_rdy) begin
                  lo_d    = bus.sdram_din;
                  state_d = ST_WHI;
               end else begin
                  state_d = ST_WLO;
               end
            end
         end
         ST_WLO: begin
            if (bus.data_rdy) begin
               lo_d    = bus.sdram_din;
               state_d = ST_WHI;
            end
         end
         ST_WHI: begin
            if (bus.data_rdy) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      req_w    = 1'b0;
      fill_en  = 1'b0;
      fill_vld = 1'b0;
      unique case (state_q)
         ST_REQ: req_w = 1'b1;
         ST_WHI: begin
            fill_en  = bus.data_rdy;
            fill_vld = !(flushed_q || bus.flush);
         end
         default: ;
      endcase
   end

   assign bus.ok         = ok_w;
   assign bus.dout       = dout_w;
   assign bus.sdram_req  = req_w;
   assign bus.sdram_addr = OFFSET + 22'({tag_q, 1'b0});

endmodule

// File: doc/jtkicker_rom_slot.md
# jtkicker_rom_slot

SDRAM-side responder for the 13-bit, 32-bit-wide graphics ROM port driven by the scroll and object layers. It accepts a ROM address and `cs` from a video layer and answers with `dout` and `ok`. Misses are served by a two-word 16-bit SDRAM burst into a two-entry cache, so a layer toggling between two tile rows never refetches. It sits between each video layer and the SDRAM arbiter in the game top level.

## Interface
Parameters:
- `AW`, 13, client address width (32-bit words).
- `OFFSET`, 22'h0, SDRAM 16-bit word base of this ROM region.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, 48 MHz
- `rst`  in  1  synchronous active-high reset
- `addr`  in  AW  client word address
- `cs`  in  1  client request enable
- `flush`  in  1  invalidate cache (asserted during ROM download)
- `ok`  out  1  `dout` valid for current `addr`
- `dout`  out  32  ROM data; high half = second SDRAM word
- `sdram_addr`  out  22  `OFFSET + {addr_latched, 1'b0}`
- `sdram_req`  out  1  burst request, held until `sdram_ack`
- `sdram_ack`  in  1  arbiter accepted request
- `data_rdy`  in  1  `sdram_din` valid (one pulse per word)
- `sdram_din`  in  16  SDRAM read data

## Operation
- Cache: 2 entries {valid, tag[AW-1:0], data[31:0]}, plus 1 LRU bit.
- Hit = `cs` & some entry valid with tag == `addr`.
- `ok`/`dout` are combinational from the registered entries and the current `addr`. `ok` drops in the same cycle `addr` moves to a non-cached value.
- On a hit to entry i, LRU points to entry 1-i.
- FSM states: IDLE, REQ, WLO, WHI.
  - IDLE: on `cs` & ~hit & ~`flush`, latch `addr` and go to REQ.
  - REQ: `sdram_req`=1. On `sdram_ack`, go to WLO. If `data_rdy` occurs in the ack cycle, that word counts as the low word and the FSM goes straight to WHI.
  - WLO: on `data_rdy`, store the low 16 bits and go to WHI.
  - WHI: on `data_rdy`, write {din, low} and the latched tag into the LRU entry, set it valid, flip LRU, return to IDLE.
- A change of `addr` mid-fetch does not abort the fetch. The burst completes and fills under the latched tag, then IDLE re-evaluates the new `addr`.
- `flush`: clears all valid bits in that cycle. If a fetch is in flight, it completes on the bus (the arbiter handshake must finish), but the fill is written invalid. A `flush` during the WHI completion cycle wins, and the entry stays invalid.
- `data_rdy` in IDLE is ignored.
- `cs`=0: `ok`=0, and no new fetch starts.

## Timing
- Reset values: `ok`=0, `dout`=0 (entries cleared), `sdram_req`=0, `sdram_addr`=OFFSET, FSM=IDLE, valid=0, LRU=0. Reset mid-burst abandons the fetch immediately, and subsequent `data_rdy` pulses are ignored.
- Hit latency: 0 cycles (`ok` in the same cycle `addr` is presented).
- Miss latency:
  - Cycle 0: miss detected.
  - Cycle 1: `sdram_req`=1 and `sdram_addr` valid.
  - `ok` rises in the cycle after the second `data_rdy`.
  - Minimum: 3 cycles, with ack and both words back-to-back starting at cycle 1.
- `sdram_addr` is stable from the REQ entry until return to IDLE.
- Address arithmetic: the 22-bit sum wraps modulo 2^22, with no saturation.

## Structure
- Package `jtkicker_rom_pkg`:
  - FSM state encoding (2 bits).
  - Default `AW`.
  - Cache entry count constant (2).
- Natural sub-module: `jtkicker_rom_cache`.
  - Holds the entry storage, tag compare, LRU and the fill/flush ports.
  - Parent keeps the FSM and SDRAM handshake.

## Test plan
- Reset: hold `rst` 4 cycles with `data_rdy` toggling. Required: `ok`=0, `sdram_req`=0, `sdram_addr`=OFFSET; no state change afterwards until `cs`.
- Miss then hit:
  - Stimulus: `addr`=13'h0123, `cs`=1; ack 2 cycles after req; words 16'hBEEF then 16'hDEAD.
  - Required: `sdram_addr`=OFFSET+22'h0246, `dout`=32'hDEADBEEF, `ok` one cycle after the second word.
  - Re-presenting 13'h0123 gives `ok` in the same cycle, with no `sdram_req`.
- Two-entry reuse and eviction:
  - Fetch A=13'h0010 and B=13'h0020, then alternate A/B 10 times: zero requests.
  - Then C=13'h0030: evicts the LRU entry (A if B was hit last). A then refetches; B still hits.
- Address change mid-fetch: `addr` goes from A to B during WLO. Required: the burst completes, A is filled, then B is requested immediately. `ok` stays 0 until B's data arrives.
- Flush mid-fetch: `flush` pulses during WHI, or with the final `data_rdy`. Required: the handshake completes and no entry is valid afterwards. The same `addr` triggers a new request.
- Reset mid-burst: `rst` asserted in WLO, and a `data_rdy` arrives after release. Required: the FSM stays in IDLE, no entry is valid, and `ok`=0.
